// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR / interrupt unit.
//   - CSR address constants for the implemented registers
//   - Zicsr operation encoding (funct3[1:0])
//   - bit positions of the mstatus / mie / mip fields that are implemented
//   - csr_alu: the read-modify-write data path shared by all writable CSRs
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIE_MTIE     = 7;

    // New CSR value for a given op; an undefined op leaves the value unchanged.
    function automatic logic [31:0] csr_alu(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = wdata;
            CSR_RS:  res = old_val | wdata;
            CSR_RC:  res = old_val & ~wdata;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running event counter used for cycle and instret.
//   clk   in  1   clock
//   rst_n in  1   asynchronous active-low reset, clears the count
//   inc   in  1   count one event this cycle
//   q     out 64  current count; wraps from all-ones to zero
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [63:0] q
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Next count: natural 64-bit wrap on overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + 64'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/csr_interrupt_unit.sv
// csr_interrupt_unit: machine-mode CSR file and interrupt state for the 5-stage core.
// Executes Zicsr ops from EX, holds mstatus/mie/mip/mtvec/mepc, synchronises the raw
// IRQ lines into mip, commits trap entry / mret, and keeps cycle/instret counters.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   csr_en, csr_stall               CSR op valid in EX / EX stalled (no write)
//   csr_addr, csr_func              CSR address, op (01 RW, 10 RS, 11 RC)
//   csr_wdata, csr_wzero            operand, operand-source-is-zero (RS/RC skip write)
//   csr_rdata                       old CSR value (combinational)
//   ext_irq, timer_irq              raw asynchronous level interrupts
//   interrupt_taken, interrupt_return, trap_mepc   trap / mret commit and saved PC
//   retire                          one instruction retired this cycle
//   mstatus_mie, mie_meie, mie_mtie, mip_meip, mip_mtip, mtvec_q, mepc_q  registered state
// IRQ_SYNC_STAGES must be 1..3.
module csr_interrupt_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  logic        csr_stall,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_func,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wzero,
    output logic [31:0] csr_rdata,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        interrupt_taken,
    input  logic        interrupt_return,
    input  logic [31:0] trap_mepc,
    input  logic        retire,
    output logic        mstatus_mie,
    output logic        mie_meie,
    output logic        mie_mtie,
    output logic        mip_meip,
    output logic        mip_mtip,
    output logic [31:0] mtvec_q,
    output logic [31:0] mepc_q
);

    logic [IRQ_SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic [IRQ_SYNC_STAGES-1:0] tmr_sync_q, tmr_sync_d;

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic [31:0] mtvec_d;
    logic [31:0] mepc_d;

    logic [63:0] cycle_s;
    logic [63:0] instret_s;

    csr_op_e     csr_op_s;
    logic        write_op_s;
    logic        csr_we_s;
    logic [31:0] csr_old_s;
    logic [31:0] csr_new_s;

    csr_counter64 u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .q     (cycle_s)
    );

    csr_counter64 u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .q     (instret_s)
    );

    // Shift the raw IRQ levels into their synchroniser chains; stage 0 is the newest.
    always_comb begin
        ext_sync_d    = ext_sync_q << 1'b1;
        ext_sync_d[0] = ext_irq;
        tmr_sync_d    = tmr_sync_q << 1'b1;
        tmr_sync_d[0] = timer_irq;
    end

    // Read mux: pre-write value of the addressed CSR; unimplemented addresses read zero.
    always_comb begin
        csr_old_s = 32'd0;
        case (csr_addr)
            CSR_MSTATUS:  csr_old_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            CSR_MIE:      csr_old_s = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
            CSR_MTVEC:    csr_old_s = mtvec_q;
            CSR_MEPC:     csr_old_s = mepc_q;
            CSR_MIP:      csr_old_s = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};
            CSR_CYCLE:    csr_old_s = cycle_s[31:0];
            CSR_CYCLEH:   csr_old_s = cycle_s[63:32];
            CSR_INSTRET:  csr_old_s = instret_s[31:0];
            CSR_INSTRETH: csr_old_s = instret_s[63:32];
            default:      csr_old_s = 32'd0;
        endcase
    end

    assign csr_rdata = csr_old_s;

    // Decode whether this op writes at all: RS/RC with a zero source are pure reads.
    always_comb begin
        csr_op_s   = csr_op_e'(csr_func);
        write_op_s = 1'b0;
        case (csr_op_s)
            CSR_RW:         write_op_s = 1'b1;
            CSR_RS, CSR_RC: write_op_s = ~csr_wzero;
            default:        write_op_s = 1'b0;
        endcase
        csr_we_s  = csr_en & ~csr_stall & write_op_s;
        csr_new_s = csr_alu(csr_op_s, csr_old_s, csr_wdata);
    end

    // State update: trap beats mret beats CSR write; a flushed CSR write is dropped.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        if (interrupt_taken) begin
            mepc_d         = trap_mepc & ~32'h0000_0003;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (interrupt_return) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we_s) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_new_s[MSTATUS_MIE];
                    mstatus_mpie_d = csr_new_s[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mie_meie_d = csr_new_s[MIE_MEIE];
                    mie_mtie_d = csr_new_s[MIE_MTIE];
                end
                CSR_MTVEC: mtvec_d = csr_new_s & ~32'h0000_0003;
                CSR_MEPC:  mepc_d  = csr_new_s & ~32'h0000_0003;
                default:   mepc_d  = mepc_q;
            endcase
        end else begin
            mepc_d = mepc_q;
        end
    end

    // Architectural state and synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q     <= '0;
            tmr_sync_q     <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & ~32'h0000_0003;
            mepc_q         <= 32'd0;
        end else begin
            ext_sync_q     <= ext_sync_d;
            tmr_sync_q     <= tmr_sync_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
        end
    end

    assign mstatus_mie = mstatus_mie_q;
    assign mie_meie    = mie_meie_q;
    assign mie_mtie    = mie_mtie_q;
    assign mip_meip    = ext_sync_q[IRQ_SYNC_STAGES-1];
    assign mip_mtip    = tmr_sync_q[IRQ_SYNC_STAGES-1];

endmodule

// File: tb/tb_csr_interrupt_unit.sv
// Self-checking bench for csr_interrupt_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_csr_interrupt_unit;

    localparam int          N_SYNC         = 2;
    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic        csr_stall = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [1:0]  csr_func = 2'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic        csr_wzero = 1'b0;
    logic [31:0] csr_rdata;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic        interrupt_taken = 1'b0;
    logic        interrupt_return = 1'b0;
    logic [31:0] trap_mepc = 32'd0;
    logic        retire = 1'b0;
    logic        mstatus_mie, mie_meie, mie_mtie, mip_meip, mip_mtip;
    logic [31:0] mtvec_q, mepc_q;

    csr_interrupt_unit #(
        .MTVEC_RESET     (TB_MTVEC_RESET),
        .IRQ_SYNC_STAGES (N_SYNC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_en           (csr_en),
        .csr_stall        (csr_stall),
        .csr_addr         (csr_addr),
        .csr_func         (csr_func),
        .csr_wdata        (csr_wdata),
        .csr_wzero        (csr_wzero),
        .csr_rdata        (csr_rdata),
        .ext_irq          (ext_irq),
        .timer_irq        (timer_irq),
        .interrupt_taken  (interrupt_taken),
        .interrupt_return (interrupt_return),
        .trap_mepc        (trap_mepc),
        .retire           (retire),
        .mstatus_mie      (mstatus_mie),
        .mie_meie         (mie_meie),
        .mie_mtie         (mie_mtie),
        .mip_meip         (mip_meip),
        .mip_mtip         (mip_mtip),
        .mtvec_q          (mtvec_q),
        .mepc_q           (mepc_q)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_mie, m_mpie, m_meie, m_mtie;
    logic [31:0] m_mtvec, m_mepc;
    logic [63:0] m_cycle, m_instret;
    bit          ext_hist[$];
    bit          tmr_hist[$];

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0; m_mtie = 1'b0;
        m_mtvec = TB_MTVEC_RESET & 32'hFFFF_FFFC;
        m_mepc = 32'd0; m_cycle = 64'd0; m_instret = 64'd0;
        ext_hist.delete(); tmr_hist.delete();
        for (int i = 0; i < N_SYNC; i++) begin
            ext_hist.push_back(1'b0);
            tmr_hist.push_back(1'b0);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h304: return (m_meie ? 32'h800 : 32'h0) | (m_mtie ? 32'h80 : 32'h0);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h344: return (ext_hist[N_SYNC-1] ? 32'h800 : 32'h0) | (tmr_hist[N_SYNC-1] ? 32'h80 : 32'h0);
            12'hC00: return m_cycle[31:0];
            12'hC80: return m_cycle[63:32];
            12'hC02: return m_instret[31:0];
            12'hC82: return m_instret[63:32];
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] mo_old, mo_new;
    bit          mo_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            mo_old = model_read(csr_addr);
            mo_new = mo_old;
            mo_wr  = 1'b0;
            case (csr_func)
                2'b01: begin mo_new = csr_wdata;            mo_wr = 1'b1;       end
                2'b10: begin mo_new = mo_old | csr_wdata;   mo_wr = !csr_wzero; end
                2'b11: begin mo_new = mo_old & ~csr_wdata;  mo_wr = !csr_wzero; end
                default: mo_wr = 1'b0;
            endcase
            mo_wr = mo_wr && csr_en && !csr_stall;
            if (interrupt_taken) begin
                m_mepc = trap_mepc & 32'hFFFF_FFFC;
                m_mpie = m_mie;
                m_mie  = 1'b0;
            end else if (interrupt_return) begin
                m_mie  = m_mpie;
                m_mpie = 1'b1;
            end else if (mo_wr) begin
                case (csr_addr)
                    12'h300: begin m_mie = mo_new[3]; m_mpie = mo_new[7]; end
                    12'h304: begin m_meie = mo_new[11]; m_mtie = mo_new[7]; end
                    12'h305: m_mtvec = mo_new & 32'hFFFF_FFFC;
                    12'h341: m_mepc  = mo_new & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            ext_hist.push_front(ext_irq);   void'(ext_hist.pop_back());
            tmr_hist.push_front(timer_irq); void'(tmr_hist.pop_back());
            m_cycle = m_cycle + 64'd1;
            if (retire) m_instret = m_instret + 64'd1;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("mstatus_mie", 64'(mstatus_mie), 64'(m_mie));
        check("mie_meie",    64'(mie_meie),    64'(m_meie));
        check("mie_mtie",    64'(mie_mtie),    64'(m_mtie));
        check("mip_meip",    64'(mip_meip),    64'(ext_hist[N_SYNC-1]));
        check("mip_mtip",    64'(mip_mtip),    64'(tmr_hist[N_SYNC-1]));
        check("mtvec_q",     64'(mtvec_q),     64'(m_mtvec));
        check("mepc_q",      64'(mepc_q),      64'(m_mepc));
        if (csr_en) check("csr_rdata", 64'(csr_rdata), 64'(model_read(csr_addr)));
    end

    // ---------------- stimulus ----------------
    logic [11:0] addr_tab [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic en, input logic [11:0] a, input logic [1:0] f,
                      input logic [31:0] wd, input logic wz);
        csr_en = en; csr_addr = a; csr_func = f; csr_wdata = wd; csr_wzero = wz;
        csr_stall = 1'b0;
    endtask

    task automatic idle();
        op(1'b0, 12'h000, 2'b00, 32'd0, 1'b0);
        interrupt_taken = 1'b0; interrupt_return = 1'b0; trap_mepc = 32'd0; retire = 1'b0;
    endtask

    task automatic do_op(input logic [11:0] a, input logic [1:0] f,
                         input logic [31:0] wd, input logic wz);
        op(1'b1, a, f, wd, wz);
        tick();
        idle();
    endtask

    int lat;

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mtvec", 64'(mtvec_q), 64'(TB_MTVEC_RESET));
        check("rst_mie",   64'(mstatus_mie), 64'd0);
        check("rst_mepc",  64'(mepc_q), 64'd0);
        rst_n = 1'b1;

        // CSRRW mtvec: old value read, low bits forced to zero on write
        op(1'b1, 12'h305, 2'b01, 32'h0000_1003, 1'b0);
        @(negedge clk); check("rw_mtvec_old", 64'(csr_rdata), 64'(TB_MTVEC_RESET));
        tick(); idle();
        @(negedge clk); check("rw_mtvec_new", 64'(mtvec_q), 64'h0000_1000);
        tick();

        // mstatus set / clear with and without zero source
        do_op(12'h300, 2'b10, 32'h8, 1'b0);
        @(negedge clk); check("rs_mie_set", 64'(mstatus_mie), 64'd1);
        tick();
        do_op(12'h300, 2'b11, 32'h0, 1'b1);
        @(negedge clk); check("rc_wzero_keep", 64'(mstatus_mie), 64'd1);
        tick();
        do_op(12'h300, 2'b11, 32'h8, 1'b0);
        @(negedge clk); check("rc_mie_clr", 64'(mstatus_mie), 64'd0);
        tick();

        // external IRQ latency through the synchroniser
        do_op(12'h300, 2'b10, 32'h8, 1'b0);
        do_op(12'h304, 2'b10, 32'h800, 1'b0);
        ext_irq = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (mip_meip && lat == 0) lat = k;
        end
        check("irq_sync_latency", 64'(lat), 64'(N_SYNC));
        ext_irq = 1'b0;

        // trap with a colliding CSRRW to mepc: trap wins, write dropped
        op(1'b1, 12'h341, 2'b01, 32'hDEAD_0000, 1'b0);
        interrupt_taken = 1'b1; trap_mepc = 32'h0000_0206;
        tick(); idle();
        @(negedge clk);
        check("trap_mepc", 64'(mepc_q), 64'h0000_0204);
        check("trap_mie",  64'(mstatus_mie), 64'd0);
        tick();
        op(1'b1, 12'h300, 2'b10, 32'd0, 1'b1);
        @(negedge clk); check("trap_mstatus", 64'(csr_rdata), 64'h0000_1880);
        tick(); idle();
        interrupt_return = 1'b1;
        tick(); idle();
        op(1'b1, 12'h300, 2'b10, 32'd0, 1'b1);
        @(negedge clk); check("mret_mstatus", 64'(csr_rdata), 64'h0000_1888);
        tick(); idle();

        // trap and mret together: trap only
        interrupt_taken = 1'b1; interrupt_return = 1'b1; trap_mepc = 32'h0000_0301;
        tick(); idle();
        @(negedge clk);
        check("both_mie",  64'(mstatus_mie), 64'd0);
        check("both_mepc", 64'(mepc_q), 64'h0000_0300);
        tick();

        // cycle counter wrap
        force dut.u_cycle_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_cycle_cnt.cnt_q;
        op(1'b1, 12'hC80, 2'b10, 32'd0, 1'b1);
        @(negedge clk); check("cycleh_max", 64'(csr_rdata), 64'h0000_0000_FFFF_FFFF);
        tick();
        @(negedge clk); check("cycleh_wrap", 64'(csr_rdata), 64'd0);
        tick();
        op(1'b1, 12'hC00, 2'b10, 32'd0, 1'b1);
        @(negedge clk); check("cycle_after_wrap", 64'(csr_rdata), 64'd1);
        tick(); idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            csr_en    = 1'($urandom_range(0, 1));
            csr_stall = ($urandom_range(0, 3) == 0);
            csr_addr  = addr_tab[$urandom_range(0, 9)];
            csr_func  = 2'($urandom_range(0, 3));
            csr_wzero = ($urandom_range(0, 3) == 0);
            csr_wdata = csr_wzero ? 32'd0 : $urandom;
            interrupt_taken  = ($urandom_range(0, 15) == 0);
            interrupt_return = ($urandom_range(0, 11) == 0);
            trap_mepc = $urandom;
            retire    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ext_irq   = ~ext_irq;
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            tick();
        end
        idle();

        // mid-run asynchronous reset, then instret counting
        do_op(12'h305, 2'b01, 32'h0000_ABC4, 1'b0);
        ext_irq = 1'b1; timer_irq = 1'b1;
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_mtvec", 64'(mtvec_q), 64'(TB_MTVEC_RESET));
        check("mrst_mie",   64'(mstatus_mie), 64'd0);
        check("mrst_meip",  64'(mip_meip), 64'd0);
        check("mrst_mtip",  64'(mip_mtip), 64'd0);
        check("mrst_mepc",  64'(mepc_q), 64'd0);
        ext_irq = 1'b0; timer_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        retire = 1'b1;
        repeat (5) tick();
        retire = 1'b0;
        op(1'b1, 12'hC02, 2'b10, 32'd0, 1'b1);
        @(negedge clk); check("instret_5", 64'(csr_rdata), 64'd5);
        tick(); idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
